fft_frame_collector: RTL and testbench
======================================

# fft_frame_collector

- Upstream stage of the sequential N-point FFT.
- Collects a serial stream of WIDTH-bit samples into SAMPLES-entry frames using two ping-pong banks, then presents each completed frame as a parallel array that the FFT controller samples.
- One bank can fill while the other is held stable for the FFT. The FFT's completion handshake releases the held bank.

## Interface
- WIDTH, 32: bits per sample; contents are opaque, passed through unmodified.
- SAMPLES, 16: samples per frame; power of two, ≥2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset rst, synchronous, active-high.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  collector can accept a sample this cycle.
- in_data  in  WIDTH  sample.
- in_last  in  1  marks the final sample of a frame; may arrive early.
- frame_out  out  [WIDTH-1:0] × SAMPLES  presented frame; index 0 = first sample received.
- frame_valid  out  1  frame_out holds a complete frame.
- frame_short  out  1  presented frame was closed by in_last before SAMPLES samples; qualified by frame_valid.
- frame_ready  in  1  consumer releases the presented frame.

## Operation
- Two banks, B0 and B1. Each bank has a state EMPTY, FILLING or FULL, plus a short flag.
- fill_sel selects the bank being written; pres_sel selects the bank driven onto frame_out. Banks are used strictly alternately; frames leave in arrival order.
- wr_idx, $clog2(SAMPLES) bits, is the write index within the fill bank.
- A sample is accepted when in_valid && in_ready:
  - It is written to bank[fill_sel][wr_idx].
  - The bank goes EMPTY→FILLING on its first sample.
- Frame close happens on an accepted sample with wr_idx==SAMPLES-1 or in_last=1:
  - The bank becomes FULL.
  - short = (wr_idx != SAMPLES-1).
  - wr_idx returns to 0 and fill_sel toggles.
- in_last on index SAMPLES-1 is a normal close with short=0. No in_last on that index still closes the frame; nothing is flagged.
- Unwritten slots of a short frame read 0, because each bank is cleared to all-zero when it is released.
- in_ready = bank[fill_sel] != FULL.
- frame_valid = bank[pres_sel]==FULL. frame_out = bank[pres_sel] contents; frame_short = bank[pres_sel].short.
- Release: frame_valid && frame_ready.
  - The presented bank is zeroed and set EMPTY, and its short flag is cleared.
  - pres_sel toggles.
- frame_ready while frame_valid=0 is ignored.
- Simultaneous close of one bank and release of the other in the same cycle: both take effect. frame_valid remains 1, and frame_out shows the newly closed bank the next cycle.
- Release and an accept can never target the same bank in the same cycle, because a FULL bank is never the fill bank with in_ready=1.
- frame_out is stable while frame_valid=1 and frame_ready=0.
- Reset values:
  - Both banks zero and EMPTY.
  - fill_sel=0, pres_sel=0, wr_idx=0.
  - frame_valid=0, frame_short=0, frame_out all zero.
  - in_ready=0 while rst=1, and 1 on the first cycle after rst drops.
- rst mid-fill or mid-hold discards all partial and held frames. The next accepted sample lands in B0[0].

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from in_valid or frame_ready to in_ready or frame_valid.
- Latency: the sample closing a frame is accepted on cycle t.
  - frame_valid=1 at t+1 if the other bank is not still presented.
  - Otherwise frame_valid=1 the cycle after that bank's release.
- Release on cycle t:
  - The bank is zeroed at t+1.
  - in_ready is 1 at t+1 if it had been blocked on that bank.
- Sustained throughput is 1 sample/cycle when the consumer releases each frame within SAMPLES cycles of its presentation.
- Back-pressure: with both banks FULL, in_ready=0 until a release. No sample is ever dropped or overwritten.

## Test plan
- **Single frame:** after reset, feed 1..16 on consecutive cycles, frame_ready=0.
  - frame_valid=1 the cycle after the 16th accept.
  - frame_out[i]=i+1, frame_short=0.
  - Values held unchanged for 20 cycles.
- **Back-pressure:** feed 48 samples continuously, frame_ready=0.
  - in_ready drops after 32 accepts.
  - Pulse frame_ready one cycle: in_ready=1 the next cycle, and frame_out shows samples 17..32.
- **Short frame:** samples 0xA0..0xA4 with in_last on 0xA4.
  - frame_out[0..4]=0xA0..0xA4, frame_out[5..15]=0, frame_short=1.
  - The following full frame reports frame_short=0.
- **Simultaneous close/release:** hold frame A presented; the last sample of frame B is accepted in the same cycle that frame_ready releases A.
  - Next cycle: frame_valid=1, frame_out=B.
  - Bank A zeroed and writable, no sample lost.
- **Reset mid-operation:** accept 7 samples, assert rst for 1 cycle, then feed 16 samples 0x100..0x10F.
  - frame_valid=0 throughout reset.
  - Resulting frame is exactly 0x100..0x10F, short=0.
- **Gappy input:** in_valid randomly low 50% of cycles over 4 frames, frame_ready random.
  - Scoreboard shows frames delivered in order and bit-exact.
  - frame_out never changes while frame_valid && !frame_ready.

Source files
------------

// File: rtl/fft_frame_collector.sv
// Ping-pong frame collector in front of the sequential FFT.
// One bank fills from the sample stream while the other is held on frame_out until the FFT releases it.
module fft_frame_collector #(
    parameter int WIDTH   = 32,
    parameter int SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic [WIDTH-1:0] frame_out [SAMPLES],
    output logic             frame_valid,
    output logic             frame_short,
    input  logic             frame_ready
);

    localparam int IDX_W = $clog2(SAMPLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL
    } bank_state_t;

    bank_state_t      bank_state [2];
    logic             bank_short [2];
    logic [WIDTH-1:0] bank_mem   [2][SAMPLES];
    logic             fill_sel;
    logic             pres_sel;
    logic [IDX_W-1:0] wr_idx;

    logic accept;
    logic rel_frame;
    logic close_frame;

    // Banks strictly alternate, so the fill bank is FULL only when both banks hold frames.
    assign in_ready    = !rst && (bank_state[fill_sel] != FULL);
    assign frame_valid = !rst && (bank_state[pres_sel] == FULL);
    assign frame_short = frame_valid && bank_short[pres_sel];

    assign accept      = in_valid && in_ready;
    assign rel_frame   = frame_valid && frame_ready;
    assign close_frame = accept && ((wr_idx == LAST_IDX) || in_last);

    always_comb begin
        for (int i = 0; i < SAMPLES; i++) begin
            frame_out[i] = bank_mem[pres_sel][i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the sample storage is reset (and re-zeroed on release) on purpose: unwritten slots of a short frame must read 0.
            for (int b = 0; b < 2; b++) begin
                bank_state[b] <= EMPTY;
                bank_short[b] <= 1'b0;
                for (int i = 0; i < SAMPLES; i++) begin
                    bank_mem[b][i] <= '0;
                end
            end
            fill_sel <= 1'b0;
            pres_sel <= 1'b0;
            wr_idx   <= '0;
        end else begin
            if (accept) begin
                bank_mem[fill_sel][wr_idx] <= in_data;
                if (close_frame) begin
                    bank_state[fill_sel] <= FULL;
                    bank_short[fill_sel] <= (wr_idx != LAST_IDX);
                    wr_idx               <= '0;
                    fill_sel             <= !fill_sel;
                end else begin
                    bank_state[fill_sel] <= FILLING;
                    wr_idx               <= wr_idx + 1'b1;
                end
            end
            // A released bank is FULL, hence never the bank being written this cycle.
            if (rel_frame) begin
                for (int i = 0; i < SAMPLES; i++) begin
                    bank_mem[pres_sel][i] <= '0;
                end
                bank_state[pres_sel] <= EMPTY;
                bank_short[pres_sel] <= 1'b0;
                pres_sel             <= !pres_sel;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_collector.sv
// Self-checking bench for fft_frame_collector: directed scenarios plus random gappy traffic,
// compared every cycle against a frame-queue reference model.
module tb_fft_frame_collector;

    localparam int W  = 32;
    localparam int N  = 16;
    localparam int FW = W * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic [W-1:0] frame_out [N];
    logic         frame_valid;
    logic         frame_short;
    logic         frame_ready;

    logic [FW-1:0] dut_flat;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: completed frames waiting for the consumer, plus the frame being assembled.
    logic [FW-1:0] pend_data [$];
    bit            pend_short[$];
    logic [FW-1:0] part;
    int            part_n;
    bit            m_rst;
    bit            m_acc;

    fft_frame_collector #(.WIDTH(W), .SAMPLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .frame_out  (frame_out),
        .frame_valid(frame_valid),
        .frame_short(frame_short),
        .frame_ready(frame_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dut_flat[i*W +: W] = frame_out[i];
        end
    end

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit v, input logic [W-1:0] d, input bit last,
                                input bit fr, input bit r);
        bit rel;
        bit acc;
        m_acc = 1'b0;
        if (r) begin
            pend_data.delete();
            pend_short.delete();
            part   = '0;
            part_n = 0;
        end else begin
            rel = fr && (pend_data.size() > 0);
            acc = v && (pend_data.size() < 2);
            if (rel) begin
                void'(pend_data.pop_front());
                void'(pend_short.pop_front());
            end
            if (acc) begin
                part[part_n*W +: W] = d;
                part_n++;
                m_acc = 1'b1;
                if (part_n == N || last) begin
                    pend_data.push_back(part);
                    pend_short.push_back(part_n != N);
                    part   = '0;
                    part_n = 0;
                end
            end
        end
        m_rst = r;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = !m_rst && (pend_data.size() > 0);
        check("in_ready", in_ready, !m_rst && (pend_data.size() < 2));
        check("frame_valid", frame_valid, exp_valid);
        if (exp_valid) begin
            check("frame_short", frame_short, pend_short[0]);
            check("frame_out", dut_flat, pend_data[0]);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check outputs on the falling edge.
    task automatic step(input bit v, input logic [W-1:0] d, input bit last,
                        input bit fr, input bit r);
        in_valid    = v;
        in_data     = d;
        in_last     = last;
        frame_ready = fr;
        rst         = r;
        @(posedge clk);
        model_update(v, d, last, fr, r);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && pend_data.size() > 0; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("drain_empty", frame_valid, 1'b0);
    endtask

    initial begin
        int sent;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        rst         = 1'b1;
        part        = '0;
        part_n      = 0;
        m_rst       = 1'b1;
        @(negedge clk);

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_ready_low", in_ready, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_out_zero", dut_flat, '0);
        check("rst_ready_up", in_ready, 1'b1);

        // Single frame 1..16, held for 20 cycles
        for (int i = 0; i < N; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0);
        check("single_valid", frame_valid, 1'b1);
        check("single_first", frame_out[0], 1);
        check("single_last", frame_out[15], 16);
        check("single_short", frame_short, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("single_hold", frame_out[7], 8);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("single_released", frame_valid, 1'b0);

        // Back-pressure: both banks fill, then one release reopens input
        sent = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, W'(sent + 1), 1'b0, 1'b0, 1'b0);
            if (m_acc) sent++;
        end
        check("bp_ready_low", in_ready, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("bp_ready_back", in_ready, 1'b1);
        check("bp_out_first", frame_out[0], 17);
        check("bp_out_last", frame_out[15], 32);
        for (int i = 0; i < 40 && sent < 48; i++) begin
            step(1'b1, W'(sent + 1), 1'b0, 1'b0, 1'b0);
            if (m_acc) sent++;
        end
        drain();

        // Short frame then a full frame
        for (int i = 0; i < 5; i++) step(1'b1, W'(32'hA0 + i), i == 4, 1'b0, 1'b0);
        check("short_flag", frame_short, 1'b1);
        check("short_elem4", frame_out[4], 32'hA4);
        check("short_elem5", frame_out[5], 0);
        check("short_elem15", frame_out[15], 0);
        for (int i = 0; i < N; i++) step(1'b1, W'(32'hC0 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("full_after_short_valid", frame_valid, 1'b1);
        check("full_after_short_flag", frame_short, 1'b0);
        drain();

        // Close of B coinciding with release of A
        for (int i = 0; i < N; i++) step(1'b1, W'(32'h300 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N - 1; i++) step(1'b1, W'(32'h400 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, W'(32'h40F), 1'b0, 1'b1, 1'b0);
        check("sim_valid", frame_valid, 1'b1);
        check("sim_out_first", frame_out[0], 32'h400);
        check("sim_out_last", frame_out[15], 32'h40F);
        check("sim_ready", in_ready, 1'b1);
        step(1'b1, W'(32'h500), 1'b0, 1'b0, 1'b0);
        drain();
        step(1'b1, W'(32'h501), 1'b1, 1'b0, 1'b0);
        check("sim_tail_short", frame_short, 1'b1);
        check("sim_tail_first", frame_out[0], 32'h500);
        drain();

        // Reset in the middle of a fill
        for (int i = 0; i < 7; i++) step(1'b1, W'(32'h600 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_valid", frame_valid, 1'b0);
        for (int i = 0; i < N; i++) step(1'b1, W'(32'h100 + i), 1'b0, 1'b0, 1'b0);
        check("midrst_first", frame_out[0], 32'h100);
        check("midrst_last", frame_out[15], 32'h10F);
        check("midrst_short", frame_short, 1'b0);
        drain();

        // Gappy random traffic with random consumer
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)), 1'b0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "bench timeout");
    end

endmodule
